// File: rtl/serial_comparator_der_a_izq.sv
// ---------------------------------------------------------------------------
// serial_comparator_der_a_izq
//
// Sequential magnitude comparator that scans two WIDTH-bit operands one bit
// per clock, LSB first (right to left). Operands are captured in parallel
// when start is accepted in IDLE. They are then shifted right, zero-filled,
// once per cycle. Each differing bit overwrites the running relation, so
// the most significant differing bit decides the result. The final relation
// is registered onto a one-hot gt/eq/lt triple on the edge that enters DONE.
//
// Handshake: start is a request that is sampled only while busy=0 (IDLE).
// The edge that sees start=1 in IDLE accepts it and captures a_in/b_in.
// While busy=1, start is ignored. done is a one-cycle completion pulse, and
// gt/eq/lt are valid from that pulse until the next one.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      comparison request (sampled in IDLE only)
//   a_in   in   WIDTH  operand A, captured on the accepting edge
//   b_in   in   WIDTH  operand B, captured on the accepting edge
//   x      out  1      LSB of the A shift register (bit under examination)
//   y      out  1      LSB of the B shift register (bit under examination)
//   busy   out  1      high in SHIFT and DONE
//   done   out  1      one-cycle pulse while in DONE
//   gt     out  1      registered A>B
//   eq     out  1      registered A==B
//   lt     out  1      registered A<B
// ---------------------------------------------------------------------------
module serial_comparator_der_a_izq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             x,
  output logic             y,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REL_EQ = 2'd0,
    REL_GT = 2'd1,
    REL_LT = 2'd2
  } rel_t;

  state_t           state_q, state_d;
  rel_t             rel_q, rel_d;
  logic [WIDTH-1:0] sa_q, sb_q;
  logic [CW-1:0]    cnt_q;
  logic             last_bit;

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The relation after judging the current bit. A differing bit always
  // overrides the previous verdict, because it is more significant.
  always_comb begin
    rel_d = rel_q;
    if (sa_q[0] && !sb_q[0]) begin
      rel_d = REL_GT;
    end else if (!sa_q[0] && sb_q[0]) begin
      rel_d = REL_LT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q  <= '0;
      sb_q  <= '0;
      cnt_q <= '0;
      rel_q <= REL_EQ;
      gt    <= 1'b0;
      eq    <= 1'b0;
      lt    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            sa_q  <= a_in;
            sb_q  <= b_in;
            cnt_q <= '0;
            rel_q <= REL_EQ;
          end
        end
        SHIFT: begin
          rel_q <= rel_d;
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          // Counter stops at WIDTH-1; it is reloaded on the next accept.
          if (!last_bit) begin
            cnt_q <= cnt_q + CW'(1);
          end else begin
            gt <= (rel_d == REL_GT);
            eq <= (rel_d == REL_EQ);
            lt <= (rel_d == REL_LT);
          end
        end
        default: ;
      endcase
    end
  end

  // Moore outputs taken straight from registers
  assign x    = sa_q[0];
  assign y    = sb_q[0];
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule
